// File: rtl/reg_access_arbiter_pkg.sv
// Shared types and helpers for the register access arbiter.
package reg_access_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } arb_state_t;

    // Index width that stays at least one bit for a single-entry range.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_access_arbiter_if.sv
// Requester-side bus of the register access arbiter plus the register view.
interface reg_access_arbiter_if
    import reg_access_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int IDX_W = clog2_min1(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         q;
    logic                          q_valid;
    logic [IDX_W-1:0]              last_id;
    logic                          busy;

    modport master (
        output req_valid, req_data,
        input  req_ready, q, q_valid, last_id, busy
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, q, q_valid, last_id, busy
    );
endinterface

// File: rtl/reg_access_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after ptr, wrapping modulo NUM_REQ.
module rr_pick
    import reg_access_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   enc;

    // rot[0] is the requester just after ptr, so the lowest set bit wins.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [IDX_W-1:0] src;
            assign src     = IDX_W'((32'(ptr) + gi + 1) % NUM_REQ);
            assign rot[gi] = req[src];
        end
    endgenerate

    always_comb begin
        enc = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) enc = IDX_W'(k);
        end
    end

    assign any = |rot;
    assign idx = IDX_W'((32'(ptr) + 32'(enc) + 1) % NUM_REQ);
endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter granting one requester per write into a shared register,
// followed by a programmable settle period.
module reg_access_arbiter
    import reg_access_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int HOLD_CYCLES = 2
) (
    input logic                clk,
    input logic                rst,
    reg_access_arbiter_if.slave bus
);
    localparam int IDX_W = clog2_min1(NUM_REQ);

    arb_state_t            state_reg, state_next;
    logic [IDX_W-1:0]      winner_reg, winner_next;
    logic [IDX_W-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [7:0]            cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0] q_reg;
    logic                  q_valid_reg;
    logic [IDX_W-1:0]      last_id_reg;
    logic                  load;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr_reg),
        .idx (pick_idx),
        .any (pick_any)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign req_word[gi]      = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            // Ready depends only on registered state, never on req_valid.
            assign bus.req_ready[gi] = (state_reg == GRANT) && (winner_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        winner_next = winner_reg;
        rr_ptr_next = rr_ptr_reg;
        cnt_next    = cnt_reg;
        load        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    winner_next = pick_idx;
                    state_next  = GRANT;
                end
            end
            GRANT: begin
                // A withdrawn request leaves the pointer alone so it keeps priority.
                if (bus.req_valid[winner_reg]) begin
                    load        = 1'b1;
                    rr_ptr_next = winner_reg;
                    if (HOLD_CYCLES == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = HOLD;
                        cnt_next   = 8'(HOLD_CYCLES - 1);
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (cnt_reg == 8'd0) state_next = IDLE;
                else                 cnt_next   = cnt_reg - 8'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            winner_reg  <= '0;
            rr_ptr_reg  <= IDX_W'(NUM_REQ - 1);
            cnt_reg     <= '0;
            q_reg       <= '0;
            q_valid_reg <= 1'b0;
            last_id_reg <= '0;
        end else begin
            state_reg  <= state_next;
            winner_reg <= winner_next;
            rr_ptr_reg <= rr_ptr_next;
            cnt_reg    <= cnt_next;
            if (load) begin
                q_reg       <= req_word[winner_reg];
                q_valid_reg <= 1'b1;
                last_id_reg <= winner_reg;
            end
        end
    end

    assign bus.q       = q_reg;
    assign bus.q_valid = q_valid_reg;
    assign bus.last_id = last_id_reg;
    assign bus.busy    = (state_reg != IDLE);
endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench: one arbiter with a 2-cycle hold, one with no hold.
module tb_reg_access_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    reg_access_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus2 ();
    reg_access_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus0 ();

    reg_access_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .HOLD_CYCLES(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    reg_access_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .HOLD_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-22s got=%h", tag, got);
        end else begin
            $display("FAIL %-22s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_idle2();
        for (int b = 0; b < 10 && bus2.busy; b++) tick();
        check("idle_reached", 32'(bus2.busy), 32'd0);
    endtask

    initial begin
        int last_grant;
        logic [31:0] fair_data [4];

        bus2.req_valid = '0;
        bus2.req_data  = '0;
        bus0.req_valid = '0;
        bus0.req_data  = '0;
        fair_data[0] = 32'hA000_0000;
        fair_data[1] = 32'hA000_0001;
        fair_data[2] = 32'hA000_0002;
        fair_data[3] = 32'hA000_0003;

        tick();
        tick();
        rst = 1'b0;
        check("rst_q",        bus2.q,                 32'd0);
        check("rst_q_valid",  32'(bus2.q_valid),      32'd0);
        check("rst_busy",     32'(bus2.busy),         32'd0);
        check("rst_ready",    32'(bus2.req_ready),    32'd0);
        check("rst_last_id",  32'(bus2.last_id),      32'd0);
        check("rst0_q_valid", 32'(bus0.q_valid),      32'd0);

        // Single requester 2.
        bus2.req_data[2*32 +: 32] = 32'hDEAD_BEEF;
        bus2.req_data[1*32 +: 32] = 32'h1111_1111;
        bus2.req_valid = 4'b0100;
        tick();
        check("single_ready", 32'(bus2.req_ready), 32'h4);
        check("single_busy1", 32'(bus2.busy),      32'd1);
        tick();
        bus2.req_valid = 4'b0000;
        check("single_q",       bus2.q,               32'hDEAD_BEEF);
        check("single_last_id", 32'(bus2.last_id),    32'd2);
        check("single_q_valid", 32'(bus2.q_valid),    32'd1);
        check("single_ready0",  32'(bus2.req_ready),  32'd0);
        tick();
        check("single_busy3", 32'(bus2.busy), 32'd1);
        tick();
        check("single_busy4", 32'(bus2.busy), 32'd0);

        // Reset while holding after a write from requester 1.
        bus2.req_data[1*32 +: 32] = 32'h1234_5678;
        bus2.req_valid = 4'b0010;
        tick();
        check("rh_ready", 32'(bus2.req_ready), 32'h2);
        tick();
        bus2.req_valid = 4'b0000;
        check("rh_q_loaded", bus2.q, 32'h1234_5678);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rh_q",       bus2.q,              32'd0);
        check("rh_q_valid", 32'(bus2.q_valid),   32'd0);
        check("rh_busy",    32'(bus2.busy),      32'd0);
        check("rh_ready",   32'(bus2.req_ready), 32'd0);

        // All four continuously valid: 0,1,2,3,0 every 4 cycles.
        for (int i = 0; i < 4; i++) bus2.req_data[i*32 +: 32] = fair_data[i];
        bus2.req_valid = 4'b1111;
        last_grant = -1;
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 10 && bus2.req_ready == 4'b0000; b++) tick();
            check($sformatf("fair_grant%0d", g), 32'(bus2.req_ready), 32'(4'b0001 << (g % 4)));
            if (last_grant >= 0)
                check($sformatf("fair_space%0d", g), 32'(cyc - last_grant), 32'd4);
            last_grant = cyc;
            tick();
            check($sformatf("fair_q%0d", g), bus2.q, fair_data[g % 4]);
        end
        bus2.req_valid = 4'b0000;
        wait_idle2();

        // Requester 1 withdraws during its grant, then re-asserts alongside 2.
        bus2.req_data[1*32 +: 32] = 32'h5555_AAAA;
        bus2.req_valid = 4'b0010;
        tick();
        check("wd_ready", 32'(bus2.req_ready), 32'h2);
        bus2.req_valid = 4'b0000;
        tick();
        check("wd_q_kept",   bus2.q,            32'hA000_0000);
        check("wd_busy",     32'(bus2.busy),    32'd0);
        check("wd_last_id",  32'(bus2.last_id), 32'd0);
        bus2.req_valid = 4'b0110;
        tick();
        check("wd_regrant", 32'(bus2.req_ready), 32'h2);
        tick();
        bus2.req_valid = 4'b0000;
        check("wd_q",       bus2.q,            32'h5555_AAAA);
        check("wd_last_id1", 32'(bus2.last_id), 32'd1);
        wait_idle2();

        // Requester 1 arrives while requester 0 holds.
        bus2.req_data[0*32 +: 32] = 32'h0000_C0DE;
        bus2.req_data[1*32 +: 32] = 32'h0000_B0B0;
        bus2.req_valid = 4'b0001;
        tick();
        check("hq_ready0", 32'(bus2.req_ready), 32'h1);
        tick();
        bus2.req_valid = 4'b0010;
        tick();
        check("hq_hold_ready", 32'(bus2.req_ready), 32'd0);
        tick();
        check("hq_idle_busy",  32'(bus2.busy),      32'd0);
        check("hq_idle_ready", 32'(bus2.req_ready), 32'd0);
        tick();
        check("hq_ready1", 32'(bus2.req_ready), 32'h2);
        tick();
        bus2.req_valid = 4'b0000;
        check("hq_q", bus2.q, 32'h0000_B0B0);

        // No-hold instance: requesters 0 and 3 granted on alternate cycles.
        bus0.req_data[0*32 +: 32] = 32'h0A0A_0A0A;
        bus0.req_data[3*32 +: 32] = 32'h3B3B_3B3B;
        bus0.req_valid = 4'b1001;
        tick();
        check("h0_ready0", 32'(bus0.req_ready), 32'h1);
        check("h0_busy",   32'(bus0.busy),      32'd1);
        tick();
        bus0.req_valid = 4'b1000;
        check("h0_gap_ready", 32'(bus0.req_ready), 32'd0);
        check("h0_gap_busy",  32'(bus0.busy),      32'd0);
        check("h0_q0",        bus0.q,              32'h0A0A_0A0A);
        tick();
        check("h0_ready3", 32'(bus0.req_ready), 32'h8);
        tick();
        bus0.req_valid = 4'b0000;
        check("h0_q3",      bus0.q,            32'h3B3B_3B3B);
        check("h0_last_id", 32'(bus0.last_id), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
